// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), running one
// req/ack transaction at a time with wait states, timeout and a D-run fairness limit.
module mem_arbiter #(
    parameter int unsigned D_RUN_MAX = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_req_i,
    input  logic [29:0] i_addr_i,
    output logic        i_ack_o,
    output logic        i_err_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [29:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned     RunW    = $clog2(D_RUN_MAX + 1);
    localparam logic [RunW-1:0] RunMax  = RunW'(D_RUN_MAX);
    localparam logic [7:0]      TmoLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic            owner_d_q;
    logic [RunW-1:0] d_run_q;
    logic [7:0]      tmo_q;
    logic            i_ack_q, i_err_q, d_ack_q, d_err_q;
    logic [31:0]     i_rdata_q, d_rdata_q;
    logic            mem_req_q, mem_we_q;
    logic [29:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;

    logic d_grant;
    logic tmo_hit;

    // D wins unless I has been starved for D_RUN_MAX consecutive D grants.
    assign d_grant = d_req_i && !(i_req_i && (d_run_q == RunMax));
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TmoLast);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            owner_d_q   <= 1'b0;
            d_run_q     <= '0;
            tmo_q       <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (!i_req_i) begin
                d_run_q <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    tmo_q <= '0;
                    if (d_grant) begin
                        owner_d_q   <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        mem_req_q   <= 1'b1;
                        state_q     <= StBusy;
                        if (i_req_i) begin
                            d_run_q <= d_run_q + RunW'(1);
                        end
                    end else if (i_req_i) begin
                        owner_d_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= i_addr_i;
                        mem_wdata_q <= '0;
                        mem_req_q   <= 1'b1;
                        d_run_q     <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (mem_ack_i) begin
                        if (owner_d_q) begin
                            d_rdata_q <= mem_rdata_i;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_rdata_i;
                            i_ack_q   <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= StDone;
                    end else if (tmo_hit) begin
                        d_err_q   <= owner_d_q;
                        i_err_q   <= !owner_d_q;
                        mem_req_q <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    i_ack_q <= 1'b0;
                    i_err_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    d_err_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign i_ack_o     = i_ack_q;
    assign i_err_o     = i_err_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_err_o     = d_err_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
